// File: rtl/surf_scaler_bank.sv
// Bank of NCH gated, saturating trigger-rate scalers with a double-buffered readout.
// Optional build macro: SURF_SCALER_SAT_FLAG_EN adds per-channel saturation flags to read data.
module surf_scaler_bank #(
   parameter int unsigned NCH         = 17,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned ADDR_W      = 5,
   parameter int unsigned GATE_CYCLES = 33000000
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [NCH-1:0]    scal_i,
   input  logic [NCH-1:0]    mask_i,
   input  logic              ref_i,
   input  logic              mode_i,
   input  logic [ADDR_W-1:0] scal_addr_i,
   input  logic              scal_rd_i,
   output logic [CNT_W:0]    scal_dat_o,
   output logic              scal_valid_o,
   output logic              latch_o,
   output logic [15:0]       refpulse_cnt_o
);

   localparam logic [31:0]      GateLast = 32'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntMax   = '1;

   logic [NCH-1:0]   scal_q;
   logic [NCH-1:0]   cnt_edge;
   logic             ref_q;
   logic             ref_edge;
   logic             ge;
   logic [31:0]      timer_q, timer_d;
   logic [15:0]      refcnt_q, refcnt_d;
   logic [CNT_W-1:0] cnt_q [NCH];
   logic [CNT_W-1:0] cnt_d [NCH];
   logic [CNT_W-1:0] lat_q [NCH];
   logic [CNT_W-1:0] lat_d [NCH];
   logic [CNT_W:0]   rd_dat;
   logic [CNT_W:0]   dat_q;
   logic             valid_q;
   logic             latch_q;

`ifdef SURF_SCALER_SAT_FLAG_EN
   logic [NCH-1:0]   sat_q, sat_d;
   logic [NCH-1:0]   lat_sat_q, lat_sat_d;
`endif

   assign cnt_edge = scal_i & ~scal_q & ~mask_i;
   assign ref_edge = ref_i & ~ref_q;
   assign ge       = mode_i ? (timer_q == GateLast) : ref_edge;

   // Timer idles at 0 outside timer mode so a switch into mode 1 starts a full gate.
   always_comb begin
      timer_d = '0;
      if (mode_i && !ge) begin
         timer_d = timer_q + 32'd1;
      end
   end

   always_comb begin
      refcnt_d = refcnt_q;
      if (ref_edge) begin
         refcnt_d = refcnt_q + 16'd1;
      end
   end

   // An edge coincident with gate end is credited to the period that is just starting.
   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         cnt_d[k] = cnt_q[k];
         lat_d[k] = lat_q[k];
         if (ge) begin
            lat_d[k] = cnt_q[k];
            cnt_d[k] = cnt_edge[k] ? CNT_W'(1) : '0;
         end else if (cnt_edge[k] && (cnt_q[k] != CntMax)) begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
         end
      end
   end

`ifdef SURF_SCALER_SAT_FLAG_EN
   always_comb begin
      sat_d     = sat_q;
      lat_sat_d = lat_sat_q;
      if (ge) begin
         lat_sat_d = sat_q;
         sat_d     = '0;
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (cnt_edge[k] && (cnt_q[k] == CntMax)) begin
               sat_d[k] = 1'b1;
            end
         end
      end
   end
`endif

   // Reads see lat_q before this cycle's update, so a read at gate end returns the old buffer.
   always_comb begin
      rd_dat = '0;
      for (int k = 0; k < NCH; k++) begin
         if (scal_addr_i == ADDR_W'(k)) begin
`ifdef SURF_SCALER_SAT_FLAG_EN
            rd_dat = {lat_sat_q[k], lat_q[k]};
`else
            rd_dat = {1'b0, lat_q[k]};
`endif
         end
      end
      if (scal_addr_i == ADDR_W'(NCH)) begin
         rd_dat = {1'b0, CNT_W'(refcnt_q)};
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         scal_q   <= '0;
         ref_q    <= 1'b0;
         timer_q  <= '0;
         refcnt_q <= '0;
         dat_q    <= '0;
         valid_q  <= 1'b0;
         latch_q  <= 1'b0;
         for (int k = 0; k < NCH; k++) begin
            cnt_q[k] <= '0;
            lat_q[k] <= '0;
         end
      end else begin
         scal_q   <= scal_i;
         ref_q    <= ref_i;
         timer_q  <= timer_d;
         refcnt_q <= refcnt_d;
         valid_q  <= scal_rd_i;
         latch_q  <= ge;
         if (scal_rd_i) begin
            dat_q <= rd_dat;
         end
         for (int k = 0; k < NCH; k++) begin
            cnt_q[k] <= cnt_d[k];
            lat_q[k] <= lat_d[k];
         end
      end
   end

`ifdef SURF_SCALER_SAT_FLAG_EN
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         sat_q     <= '0;
         lat_sat_q <= '0;
      end else begin
         sat_q     <= sat_d;
         lat_sat_q <= lat_sat_d;
      end
   end
`endif

   assign scal_dat_o     = dat_q;
   assign scal_valid_o   = valid_q;
   assign latch_o        = latch_q;
   assign refpulse_cnt_o = refcnt_q;

endmodule

// File: tb/tb_surf_scaler_bank.sv
// Directed plus random bench for surf_scaler_bank against a per-cycle reference model.
module tb_surf_scaler_bank;

   localparam int NCH    = 5;
   localparam int CNT_W  = 4;
   localparam int ADDR_W = 3;
   localparam int GATE   = 100;
   localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef SURF_SCALER_SAT_FLAG_EN
   localparam bit SatEn = 1'b1;
`else
   localparam bit SatEn = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NCH-1:0]    scal_i;
   logic [NCH-1:0]    mask_i;
   logic              ref_i;
   logic              mode;
   logic [ADDR_W-1:0] scal_addr;
   logic              scal_rd;
   logic [CNT_W:0]    scal_dat_o;
   logic              scal_valid_o;
   logic              latch_o;
   logic [15:0]       refpulse_cnt_o;

   always #5 clk = ~clk;

   surf_scaler_bank #(
      .NCH(NCH), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .GATE_CYCLES(GATE)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .scal_i(scal_i), .mask_i(mask_i), .ref_i(ref_i),
      .mode_i(mode), .scal_addr_i(scal_addr), .scal_rd_i(scal_rd), .scal_dat_o(scal_dat_o),
      .scal_valid_o(scal_valid_o), .latch_o(latch_o), .refpulse_cnt_o(refpulse_cnt_o)
   );

   int total = 0;
   int bad   = 0;
   int latches = 0;

   // Reference model state: counts per gate period, latched buffer, refs seen.
   int m_cnt [NCH];
   int m_lat [NCH];
   bit m_sat [NCH];
   bit m_lsat[NCH];
   bit m_pscal[NCH];
   bit m_pref;
   int m_timer;
   int m_ref;
   int m_dat;
   bit m_valid;
   bit m_latch;

   task automatic check(input string tag, input logic [31:0] obs, input int exp);
      total++;
      assert (obs === 32'(exp)) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      bit redge, ge, ce;
      @(posedge clk);
      if (!rst_n) begin
         for (int k = 0; k < NCH; k++) begin
            m_cnt[k] = 0; m_lat[k] = 0; m_sat[k] = 0; m_lsat[k] = 0; m_pscal[k] = 0;
         end
         m_pref = 0; m_timer = 0; m_ref = 0; m_dat = 0; m_valid = 0; m_latch = 0;
      end else begin
         redge = ref_i && !m_pref;
         ge = mode ? (m_timer == GATE - 1) : redge;
         m_valid = scal_rd;
         if (scal_rd) begin
            if (scal_addr < NCH)
               m_dat = m_lat[scal_addr] + ((SatEn && m_lsat[scal_addr]) ? (1 << CNT_W) : 0);
            else if (scal_addr == NCH)
               m_dat = m_ref % (1 << CNT_W);
            else
               m_dat = 0;
         end
         m_latch = ge;
         for (int k = 0; k < NCH; k++) begin
            ce = scal_i[k] && !m_pscal[k] && !mask_i[k];
            if (ge) begin
               m_lat[k] = m_cnt[k]; m_lsat[k] = m_sat[k];
               m_cnt[k] = ce ? 1 : 0; m_sat[k] = 0;
            end else if (ce) begin
               if (m_cnt[k] == CMAX) m_sat[k] = 1;
               else m_cnt[k]++;
            end
            m_pscal[k] = scal_i[k];
         end
         if (redge) m_ref = (m_ref + 1) % 65536;
         m_timer = mode ? (ge ? 0 : m_timer + 1) : 0;
         m_pref = ref_i;
      end
      #1;
      check("latch_o", 32'(latch_o), int'(m_latch));
      check("scal_valid_o", 32'(scal_valid_o), int'(m_valid));
      check("scal_dat_o", 32'(scal_dat_o), m_dat);
      check("refpulse_cnt_o", 32'(refpulse_cnt_o), m_ref);
      if (latch_o === 1'b1) latches++;
   endtask

   task automatic pulse(input int ch);
      scal_i[ch] = 1'b1; tick();
      scal_i[ch] = 1'b0; tick();
   endtask

   task automatic do_read(input int a);
      scal_addr = ADDR_W'(a); scal_rd = 1'b1; tick();
      scal_rd = 1'b0;
   endtask

   task automatic wait_latch();
      int n = 0;
      do begin tick(); n++; end while (latch_o !== 1'b1 && n < 300);
      check("latch_seen", 32'(latch_o), 1);
   endtask

   int r0;

   initial begin
      rst_n = 1'b0; scal_i = '0; mask_i = '0; ref_i = 1'b0; mode = 1'b1;
      scal_addr = '0; scal_rd = 1'b0;
      tick(); tick();
      rst_n = 1'b1;

      // Reset state
      do_read(0);
      check("rst_valid", 32'(scal_valid_o), 1);
      check("rst_dat", 32'(scal_dat_o), 0);
      check("rst_latch", 32'(latch_o), 0);
      check("rst_refcnt", 32'(refpulse_cnt_o), 0);

      // Timer gate, 10 edges on ch3
      repeat (10) pulse(3);
      wait_latch();
      do_read(3); check("ch3_ten", 32'(scal_dat_o), 10);
      do_read(2); check("ch2_zero", 32'(scal_dat_o), 0);

      // Saturation then a clean gate
      repeat (20) pulse(0);
      wait_latch();
      do_read(0); check("ch0_sat", 32'(scal_dat_o), CMAX + (SatEn ? (1 << CNT_W) : 0));
      wait_latch();
      do_read(0); check("ch0_clean", 32'(scal_dat_o), 0);

      // Mask: frozen gate, then unmask mid-gate
      mask_i[3] = 1'b1;
      repeat (10) pulse(3);
      wait_latch();
      do_read(3); check("ch3_masked", 32'(scal_dat_o), 0);
      repeat (10) pulse(3);
      mask_i[3] = 1'b0;
      repeat (5) pulse(3);
      wait_latch();
      do_read(3); check("ch3_unmask", 32'(scal_dat_o), 5);

      // Random traffic, timer mode then ref mode
      for (int m = 1; m >= 0; m--) begin
         mode = m[0];
         for (int i = 0; i < 700; i++) begin
            scal_i = NCH'($urandom);
            if ($urandom_range(0, 31) == 0) mask_i = NCH'($urandom);
            ref_i = ($urandom_range(0, 15) == 0);
            scal_rd = ($urandom_range(0, 2) == 0);
            scal_addr = ADDR_W'($urandom);
            tick();
         end
      end
      scal_i = '0; mask_i = '0; ref_i = 1'b0; scal_rd = 1'b0;
      tick(); tick();

      // Ref-driven gates: three short pulses and one long one
      r0 = m_ref; latches = 0;
      repeat (3) begin
         ref_i = 1'b1; tick(); ref_i = 1'b0; tick(); tick();
      end
      ref_i = 1'b1; repeat (10) tick();
      ref_i = 1'b0; tick(); tick();
      check("ref_latches", 32'(latches), 4);
      check("ref_count_delta", 32'(refpulse_cnt_o), (r0 + 4) % 65536);
      do_read(NCH); check("read_refcnt", 32'(scal_dat_o), (r0 + 4) % (1 << CNT_W));
      do_read(NCH + 1); check("read_beyond", 32'(scal_dat_o), 0);

      // Edge and read coincident with gate end
      ref_i = 1'b1; tick(); ref_i = 1'b0; tick();
      repeat (3) pulse(1);
      ref_i = 1'b1; tick(); ref_i = 1'b0; tick();
      scal_i[1] = 1'b1; ref_i = 1'b1; scal_rd = 1'b1; scal_addr = ADDR_W'(1); tick();
      check("coincident_old", 32'(scal_dat_o), 3);
      scal_rd = 1'b0; scal_i[1] = 1'b0; ref_i = 1'b0; tick();
      ref_i = 1'b1; tick(); ref_i = 1'b0; tick();
      do_read(1); check("coincident_next", 32'(scal_dat_o), 1);

      // Reset mid-gate discards counts
      mode = 1'b1;
      repeat (4) pulse(2);
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      wait_latch();
      do_read(2); check("ch2_after_rst", 32'(scal_dat_o), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
